// File: rtl/bus_uart_tx_if.sv
// CPU data-bus handshake shared with the memory block: strobe, direction,
// width, byte address, write data, and registered read data with hit.
interface bus_uart_tx_if;
  logic        en;
  logic        wr;
  logic        wide;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        hit;

  modport master (
    output en, wr, wide, addr, din,
    input  dout, hit
  );

  modport slave (
    input  en, wr, wide, addr, din,
    output dout, hit
  );
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: bus register block, small TX FIFO
// and a baud-rate shifter driving tx.
module bus_uart_tx #(
  parameter logic [15:0] BASE       = 16'hFC00,
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic         clk,
  input  logic         reset,
  bus_uart_tx_if.slave bus,
  output logic         tx,
  output logic         irq
);

  localparam int                     DEPTH    = 1 << DEPTH_LOG2;
  localparam int                     CNT_W    = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [1:0]             REG_DATA   = 2'd0;
  localparam logic [1:0]             REG_STATUS = 2'd1;
  localparam logic [1:0]             REG_DIV    = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Divisors of 0 and 1 both mean one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd1 : d;
  endfunction

  function automatic logic [15:0] byte_lane(input logic [15:0] v,
                                            input logic        wide,
                                            input logic        odd);
    if (wide)     return v;
    else if (odd) return {8'h00, v[15:8]};
    else          return {8'h00, v[7:0]};
  endfunction

  logic                  sel, rd_acc, wr_acc, odd;
  logic [1:0]            reg_idx;
  logic                  full, empty, busy, bit_end;
  logic                  push, pop, push_ok, push_drop;
  logic [15:0]           status, reg_val;

  logic [7:0]            fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  ovf;
  logic [15:0]           divisor;

  state_t                state;
  logic [15:0]           bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;

  assign sel     = bus.en & (bus.addr[15:3] == BASE[15:3]);
  assign rd_acc  = sel & ~bus.wr;
  assign wr_acc  = sel & bus.wr;
  assign reg_idx = bus.addr[2:1];
  assign odd     = ~bus.wide & bus.addr[0];

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign busy    = (state != S_IDLE);
  assign bit_end = (bit_cnt == 16'd1);
  assign irq     = empty & ~busy;

  // The shifter pops either from IDLE or on the last cycle of STOP, so
  // queued frames follow each other with no idle gap.
  assign push      = wr_acc & (reg_idx == REG_DATA) & ~odd;
  assign pop       = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign push_ok   = push & (~full | pop);
  assign push_drop = push & full & ~pop;

  always_comb begin
    status            = '0;
    status[0]         = busy;
    status[1]         = full;
    status[2]         = empty;
    status[3]         = ovf;
    status[4 +: CNT_W] = count;
  end

  always_comb begin
    reg_val = 16'h0000;
    case (reg_idx)
      REG_STATUS: reg_val = status;
      REG_DIV:    reg_val = divisor;
      default:    reg_val = 16'h0000;
    endcase
  end

  // Read stage: one registered cycle of latency, zero when not hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout <= 16'h0000;
      bus.hit  <= 1'b0;
    end else begin
      bus.hit  <= rd_acc;
      bus.dout <= rd_acc ? byte_lane(reg_val, bus.wide, bus.addr[0]) : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.din[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // The STATUS read returns the old flag while clearing it.
      if (rd_acc && reg_idx == REG_STATUS) ovf <= 1'b0;
      else if (push_drop)                  ovf <= 1'b1;
      if (wr_acc && reg_idx == REG_DIV) begin
        if (bus.wide)  divisor       <= bus.din;
        else if (odd)  divisor[15:8] <= bus.din[7:0];
        else           divisor[7:0]  <= bus.din[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                             shift <= fifo_mem[rd_ptr];
    else if (state == S_DATA && bit_end) shift <= {1'b0, shift[7:1]};
  end

  // Shifter FSM; tx is registered and presented for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            bit_cnt <= eff_div(divisor);
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= eff_div(divisor);
            bit_idx <= 3'd0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= eff_div(divisor);
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!empty) begin
              bit_cnt <= eff_div(divisor);
              tx      <= 1'b0;
              state   <= S_START;
            end else begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: register access, frame timing, FIFO
// overflow, byte lanes, back-to-back frames and mid-frame reset.
module tb_bus_uart_tx;

  localparam logic [15:0] BASE = 16'hFC00;

  logic clk = 1'b0;
  logic reset;
  logic tx, irq;
  logic [15:0] rd_dout;
  logic        rd_hit;
  int n_assert = 0;
  int n_fail   = 0;

  bus_uart_tx_if bus();

  bus_uart_tx #(
    .BASE(BASE),
    .DEPTH_LOG2(2),
    .DIV_RESET(16'd434)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .tx(tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic w);
    bus.en = 1'b1; bus.wr = 1'b1; bus.wide = w; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.en = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic w);
    bus.en = 1'b1; bus.wr = 1'b0; bus.wide = w; bus.addr = a;
    @(negedge clk);
    rd_dout = bus.dout;
    rd_hit  = bus.hit;
    bus.en  = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p == 0)      return 1'b0;
    else if (p == 9) return 1'b1;
    else             return b[p-1];
  endfunction

  initial begin
    logic [7:0] fb;
    reset = 1'b1;
    bus.en = 1'b0; bus.wr = 1'b0; bus.wide = 1'b0; bus.addr = 16'h0000; bus.din = 16'h0000;
    repeat (3) @(negedge clk);
    chk16("rst_dout", bus.dout, 16'h0000);
    chk1("rst_hit", bus.hit, 1'b0);
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_irq", irq, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    bus_rd(BASE + 16'd2, 1'b1);
    chk1("status_hit", rd_hit, 1'b1);
    chk16("status_reset", rd_dout, 16'h0004);
    chk1("idle_tx", tx, 1'b1);
    chk1("idle_irq", irq, 1'b1);

    bus_rd(16'h1002, 1'b1);
    chk1("miss_hit", rd_hit, 1'b0);
    chk16("miss_dout", rd_dout, 16'h0000);

    bus_rd(BASE + 16'd4, 1'b1);
    chk16("div_reset", rd_dout, 16'h01B2);

    // Single A5 frame at 4 clocks per bit while polling STATUS.
    bus_wr(BASE + 16'd4, 16'h0004, 1'b1);
    bus_wr(BASE, 16'h00A5, 1'b1);
    bus.en = 1'b1; bus.wr = 1'b0; bus.wide = 1'b1; bus.addr = BASE + 16'd2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk1("a5_tx", tx, frame_bit(8'hA5, i / 4));
      chk1("a5_busy", bus.dout[0], (i != 0));
      chk1("a5_irq", irq, 1'b0);
    end
    @(negedge clk);
    chk1("a5_end_tx", tx, 1'b1);
    chk1("a5_end_irq", irq, 1'b1);
    bus.en = 1'b0;

    // Five pushes: first pops at once, FIFO then holds four.
    bus_wr(BASE, 16'h0011, 1'b1);
    bus_wr(BASE, 16'h0022, 1'b1);
    bus_wr(BASE, 16'h0033, 1'b1);
    bus_wr(BASE, 16'h0044, 1'b1);
    bus_wr(BASE, 16'h0055, 1'b1);
    bus_rd(BASE + 16'd2, 1'b1);
    chk16("fifo_full", rd_dout, 16'h0043);
    bus_wr(BASE, 16'h0066, 1'b1);
    bus_rd(BASE + 16'd2, 1'b1);
    chk16("ovf_set", rd_dout, 16'h004B);
    bus_rd(BASE + 16'd2, 1'b1);
    chk16("ovf_clear", rd_dout, 16'h0043);

    for (int k = 0; k < 600; k++) begin
      if (irq) break;
      @(negedge clk);
    end
    chk1("drain_irq", irq, 1'b1);
    bus_rd(BASE + 16'd2, 1'b1);
    chk16("drain_status", rd_dout, 16'h0004);

    // Byte lanes and register map corners.
    bus_wr(BASE + 16'd5, 16'h0012, 1'b0);
    bus_rd(BASE + 16'd5, 1'b0);
    chk16("div_hi_byte", rd_dout, 16'h0012);
    bus_rd(BASE + 16'd4, 1'b1);
    chk16("div_wide", rd_dout, 16'h1204);
    bus_rd(BASE + 16'd4, 1'b0);
    chk16("div_lo_byte", rd_dout, 16'h0004);
    bus_rd(BASE, 1'b1);
    chk1("data_hit", rd_hit, 1'b1);
    chk16("data_read", rd_dout, 16'h0000);
    bus_wr(BASE + 16'd6, 16'hFFFF, 1'b1);
    bus_rd(BASE + 16'd6, 1'b1);
    chk16("reserved", rd_dout, 16'h0000);
    bus_wr(BASE + 16'd1, 16'h00AA, 1'b0);
    bus_rd(BASE + 16'd2, 1'b1);
    chk16("odd_data_ignored", rd_dout, 16'h0004);

    // Divisor 0 behaves as one clock per bit.
    bus_wr(BASE + 16'd4, 16'h0000, 1'b1);
    bus_wr(BASE, 16'h00FE, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("div0_tx", tx, frame_bit(8'hFE, i));
    end
    repeat (2) @(negedge clk);
    chk1("div0_irq", irq, 1'b1);

    // Two contiguous frames at 2 clocks per bit: 40 cycles total.
    bus_wr(BASE + 16'd4, 16'h0002, 1'b1);
    bus_rd(BASE + 16'd4, 1'b1);
    chk16("div2", rd_dout, 16'h0002);
    bus_wr(BASE, 16'h0000, 1'b1);
    bus_wr(BASE, 16'h00C3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      fb = (i < 20) ? 8'h00 : 8'hC3;
      chk1("b2b_tx", tx, frame_bit(fb, (i / 2) % 10));
      @(negedge clk);
    end
    chk1("b2b_end_tx", tx, 1'b1);
    chk1("b2b_end_irq", irq, 1'b1);

    // Reset in the middle of the DATA bits.
    bus_wr(BASE, 16'h0000, 1'b1);
    bus_wr(BASE, 16'h0055, 1'b1);
    repeat (3) @(negedge clk);
    chk1("pre_reset_tx", tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("async_tx", tx, 1'b1);
    chk1("async_irq", irq, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_rd(BASE + 16'd2, 1'b1);
    chk16("post_reset_status", rd_dout, 16'h0004);
    bus_rd(BASE + 16'd4, 1'b1);
    chk16("post_reset_div", rd_dout, 16'h01B2);
    repeat (10) @(negedge clk);
    chk1("discard_tx", tx, 1'b1);
    chk1("discard_irq", irq, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
